uart_tx_arbiter: RTL and testbench

Shares one byte-level UART transmitter between NUM_REQ independent debug message sources.
- Arbitration is round-robin per message, not per byte. A granted requester holds the transmitter until it sends a byte flagged last, so messages never interleave on the serial line.
- Sits between message formatters (counter dumps, status strings) and the single 115200-baud TX serializer on the 27 MHz clock.

---
 rtl/uart_tx_arbiter.sv | 160 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Message-level round-robin arbiter sharing one byte UART transmitter.
// Optional owner-idle forced release: define UART_ARB_LOCK_TIMEOUT_EN.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int ID_W         = 2,
    parameter int LOCK_TIMEOUT = 2700000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*8-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [7:0]           tx_data,
    output logic                 tx_start,
    input  logic                 tx_busy,
    output logic                 grant_active,
    output logic [ID_W-1:0]      grant_id,
    output logic                 lock_timeout
);

    typedef enum logic [1:0] {
        IDLE,
        LOCKED,
        ACK,
        DRAIN
    } state_t;

    state_t          state;
    logic [ID_W-1:0] ptr;
    logic            last_q;

    logic            hi_found;
    logic [ID_W-1:0] hi_id;
    logic            lo_found;
    logic [ID_W-1:0] lo_id;
    logic            pick_found;
    logic [ID_W-1:0] pick_id;

    logic            owner_valid;
    logic [7:0]      owner_data;
    logic            owner_last;

    // Elaboration-time parameter sanity; an illegal setting leaves a marker block.
    if (NUM_REQ < 2 || NUM_REQ > 8 || (1 << ID_W) < NUM_REQ || LOCK_TIMEOUT < 2)
    begin : g_bad_params
    end

    // Round-robin: lowest valid index above ptr, else lowest valid overall.
    always_comb begin
        hi_found = 1'b0;
        hi_id    = '0;
        lo_found = 1'b0;
        lo_id    = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                lo_found = 1'b1;
                lo_id    = ID_W'(i);
                if (ID_W'(i) > ptr) begin
                    hi_found = 1'b1;
                    hi_id    = ID_W'(i);
                end
            end
        end
        pick_found = hi_found | lo_found;
        pick_id    = hi_found ? hi_id : lo_id;
    end

    always_comb begin
        owner_valid = 1'b0;
        owner_data  = 8'h00;
        owner_last  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == ID_W'(i)) begin
                owner_valid = req_valid[i];
                owner_data  = req_data[i*8 +: 8];
                owner_last  = req_last[i];
            end
        end
    end

`ifdef UART_ARB_LOCK_TIMEOUT_EN
    logic [31:0] idle_cnt;
`else
    assign lock_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            ptr          <= ID_W'(NUM_REQ - 1);
            last_q       <= 1'b0;
            grant_active <= 1'b0;
            grant_id     <= '0;
            tx_data      <= 8'h00;
            tx_start     <= 1'b0;
            req_ready    <= '0;
`ifdef UART_ARB_LOCK_TIMEOUT_EN
            lock_timeout <= 1'b0;
            idle_cnt     <= '0;
`endif
        end else begin
            tx_start  <= 1'b0;
            req_ready <= '0;
`ifdef UART_ARB_LOCK_TIMEOUT_EN
            lock_timeout <= 1'b0;
            idle_cnt     <= '0;
`endif
            unique case (state)
                IDLE: begin
                    if (pick_found) begin
                        grant_id     <= pick_id;
                        grant_active <= 1'b1;
                        state        <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (owner_valid && !tx_busy) begin
                        tx_data   <= owner_data;
                        tx_start  <= 1'b1;
                        req_ready <= NUM_REQ'(1) << grant_id;
                        last_q    <= owner_last;
                        state     <= ACK;
                    end
`ifdef UART_ARB_LOCK_TIMEOUT_EN
                    else if (!owner_valid) begin
                        if (idle_cnt == 32'(LOCK_TIMEOUT - 1)) begin
                            lock_timeout <= 1'b1;
                            grant_active <= 1'b0;
                            ptr          <= grant_id;
                            state        <= IDLE;
                        end else begin
                            idle_cnt <= idle_cnt + 32'd1;
                        end
                    end
`endif
                end
                // Serializer raises busy only after this cycle, so skip one.
                ACK: begin
                    state <= DRAIN;
                end
                DRAIN: begin
                    if (!tx_busy) begin
                        if (last_q) begin
                            grant_active <= 1'b0;
                            ptr          <= grant_id;
                            state        <= IDLE;
                        end else begin
                            state <= LOCKED;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed scoreboard bench for uart_tx_arbiter with a serializer busy model.
module tb_uart_tx_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
`ifdef UART_ARB_LOCK_TIMEOUT_EN
    localparam int LT = 100;
`else
    localparam int LT = 2700000;
`endif

    logic                 clk;
    logic                 reset;
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ*8-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic [7:0]           tx_data;
    logic                 tx_start;
    logic                 tx_busy;
    logic                 grant_active;
    logic [ID_W-1:0]      grant_id;
    logic                 lock_timeout;

    uart_tx_arbiter #(
        .NUM_REQ(NUM_REQ),
        .ID_W(ID_W),
        .LOCK_TIMEOUT(LT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_data(req_data),
        .req_last(req_last),
        .req_ready(req_ready),
        .tx_data(tx_data),
        .tx_start(tx_start),
        .tx_busy(tx_busy),
        .grant_active(grant_active),
        .grant_id(grant_id),
        .lock_timeout(lock_timeout)
    );

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] data;
        logic       last;
    } exp_t;

    exp_t       sb[$];
    logic [8:0] rq[NUM_REQ][$];

    int vectors    = 0;
    int miscompares = 0;
    int busy_len   = 20;
    int ser_cnt    = 0;
    int cyc        = 0;
    int ready_cnt[NUM_REQ] = '{default: 0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Serializer: busy rises the cycle after tx_start, lasts busy_len cycles.
    initial tx_busy = 1'b0;
    always @(posedge clk) begin
        if (tx_start) begin
            tx_busy <= 1'b1;
            ser_cnt <= busy_len - 1;
        end else if (tx_busy) begin
            if (ser_cnt == 0) tx_busy <= 1'b0;
            else ser_cnt <= ser_cnt - 1;
        end
    end

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tmo(string tag, int n, int budget);
        vectors++;
        assert (n < budget) else begin
            miscompares++;
            $error("FAIL %s: observed %0d cycles waited, expected fewer than %0d",
                   tag, n, budget);
        end
    endtask

    task automatic apply();
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rq[i].size() > 0) begin
                req_valid[i]       = 1'b1;
                req_data[i*8 +: 8] = rq[i][0][7:0];
                req_last[i]        = rq[i][0][8];
            end else begin
                req_valid[i]       = 1'b0;
                req_data[i*8 +: 8] = 8'h00;
                req_last[i]        = 1'b0;
            end
        end
    endtask

    function automatic bit rq_empty();
        for (int i = 0; i < NUM_REQ; i++)
            if (rq[i].size() > 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic send(int id, logic [7:0] d, logic l, bit expect_it);
        rq[id].push_back({l, d});
        if (expect_it) sb.push_back({2'(id), d, l});
    endtask

    // Requester models: byte consumed on the edge that raises req_ready.
    initial begin
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NUM_REQ; i++)
                if (req_ready[i] && rq[i].size() > 0) void'(rq[i].pop_front());
            apply();
            @(negedge clk);
            #1;
            apply();
        end
    end

    // Output monitor: scoreboard pop on every tx_start.
    initial begin
        bit         have_prev = 1'b0;
        bit         prev_last = 1'b0;
        logic [1:0] prev_id   = '0;
        int         prev_cyc  = 0;
        logic       prev_busy = 1'b0;
        exp_t       e;
        forever begin
            @(negedge clk);
            cyc++;
            for (int i = 0; i < NUM_REQ; i++)
                if (req_ready[i]) ready_cnt[i]++;
            if (!grant_active) have_prev = 1'b0;
            if (tx_start) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", sb.size(), 1);
                end else begin
                    e = sb.pop_front();
                    chk("tx_data", tx_data, e.data);
                    chk("grant_id", grant_id, e.id);
                    chk("req_ready", req_ready, 4'b0001 << e.id);
                    chk("busy_before_start", prev_busy, 1'b0);
                    if (have_prev && !prev_last && prev_id == e.id)
                        chk("byte_gap", cyc - prev_cyc, busy_len + 3);
                    have_prev = 1'b1;
                    prev_last = e.last;
                    prev_id   = e.id;
                    prev_cyc  = cyc;
                end
            end
            prev_busy = tx_busy;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: observed no finish, expected finish before 900000");
        $fatal(1, "watchdog");
    end

    task automatic wait_sb_empty(string tag, int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        tmo(tag, n, budget);
    endtask

    task automatic wait_busy(string tag, logic lvl, int budget);
        int n = 0;
        while (tx_busy !== lvl && n < budget) begin
            @(negedge clk);
            n++;
        end
        tmo(tag, n, budget);
    endtask

    task automatic wait_done(string tag, int budget);
        int n = 0;
        while ((sb.size() != 0 || grant_active || tx_busy || !rq_empty())
               && n < budget) begin
            @(negedge clk);
            n++;
        end
        tmo(tag, n, budget);
    endtask

    initial begin
        int n;
        int base1;

        // Reset values
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_tx_start", tx_start, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_grant_active", grant_active, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_lock_timeout", lock_timeout, 0);
        reset = 1'b0;

        // 1: "Hi\r\n" from requester 0 with a 2340-cycle serializer
        busy_len = 2340;
        @(negedge clk);
        send(0, 8'h48, 1'b0, 1);
        send(0, 8'h69, 1'b0, 1);
        send(0, 8'h0D, 1'b0, 1);
        send(0, 8'h0A, 1'b1, 1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tx_start && n < 10);
        chk("t1_latency", n, 2);
        wait_sb_empty("t1_sb", 12000);
        wait_busy("t1_busy_hi", 1'b1, 10);
        wait_busy("t1_busy_lo", 1'b0, 3000);
        chk("t1_grant_held_at_busy_low", grant_active, 1);
        @(negedge clk);
        chk("t1_grant_released", grant_active, 0);
        chk("t1_ready0_pulses", ready_cnt[0], 4);
        wait_done("t1_done", 100);

        // 2: all four valid, one-byte messages, strict rotation
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        busy_len = 20;
        send(0, 8'hA0, 1'b1, 1);
        send(1, 8'hA1, 1'b1, 0);
        send(2, 8'hA2, 1'b1, 0);
        send(3, 8'hA3, 1'b1, 0);
        send(0, 8'hA4, 1'b1, 0);
        sb.push_back({2'd1, 8'hA1, 1'b1});
        sb.push_back({2'd2, 8'hA2, 1'b1});
        sb.push_back({2'd3, 8'hA3, 1'b1});
        sb.push_back({2'd0, 8'hA4, 1'b1});
        wait_done("t2_done", 1000);

        // 3: requester 2 arrives while requester 1 is mid-message
        @(negedge clk);
        base1 = ready_cnt[1];
        send(1, 8'hB0, 1'b0, 1);
        send(1, 8'hB1, 1'b0, 1);
        send(1, 8'hB2, 1'b1, 1);
        n = 0;
        while (!(grant_active && grant_id == 2'd1) && n < 20) begin
            @(negedge clk);
            n++;
        end
        tmo("t3_grant1", n, 20);
        send(2, 8'hC0, 1'b1, 1);
        n = 0;
        while ((sb.size() != 0 || grant_active || tx_busy || !rq_empty())
               && n < 1000) begin
            @(negedge clk);
            n++;
            if (req_ready[2]) chk("t3_req1_done_first", ready_cnt[1] - base1, 3);
        end
        tmo("t3_done", n, 1000);

        // 4: reset while draining requester 3's first byte
        @(negedge clk);
        send(3, 8'hD0, 1'b0, 1);
        send(3, 8'hD1, 1'b1, 0);
        wait_sb_empty("t4_sb", 50);
        wait_busy("t4_busy_hi", 1'b1, 10);
        repeat (3) @(negedge clk);
        chk("t4_owner_before_reset", grant_id, 3);
        reset = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) rq[i].delete();
        @(negedge clk);
        reset = 1'b0;
        chk("t4_tx_start", tx_start, 0);
        chk("t4_grant_active", grant_active, 0);
        chk("t4_grant_id", grant_id, 0);
        chk("t4_req_ready", req_ready, 0);
        send(3, 8'hE3, 1'b1, 0);
        send(0, 8'hE0, 1'b1, 1);
        sb.push_back({2'd3, 8'hE3, 1'b1});
        wait_done("t4_done", 500);

        // 6: busy must gate the next byte of a held message
        @(negedge clk);
        busy_len = 5;
        send(1, 8'hF0, 1'b0, 1);
        send(1, 8'hF1, 1'b0, 1);
        send(1, 8'hF2, 1'b1, 1);
        n = 0;
        while (!tx_start && n < 20) begin
            @(negedge clk);
            n++;
        end
        tmo("t6_first_start", n, 20);
        @(negedge clk);
        chk("t6_busy_after_start", tx_busy, 1);
        chk("t6_no_restart", tx_start, 0);
        wait_done("t6_done", 200);

`ifdef UART_ARB_LOCK_TIMEOUT_EN
        // 5: owner stalls after a non-last byte, forced release
        @(negedge clk);
        send(2, 8'h5A, 1'b0, 1);
        n = 0;
        while (!tx_start && n < 20) begin
            @(negedge clk);
            n++;
        end
        tmo("t5_start", n, 20);
        send(3, 8'hC3, 1'b1, 1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!lock_timeout && n < 300);
        chk("t5_timeout_cycle", n, busy_len + 102);
        chk("t5_released", grant_active, 0);
        @(negedge clk);
        chk("t5_pulse_width", lock_timeout, 0);
        chk("t5_regrant_active", grant_active, 1);
        chk("t5_regrant_id", grant_id, 3);
        wait_done("t5_done", 200);
`endif

        chk("end_lock_timeout", lock_timeout, 0);
        chk("end_sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
